// File: rtl/wire_ops_pkg.sv
// Shared types and constants for the WireOps self-checking driver.
// Also holds the golden model of the WireOps result.
package wire_ops_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } wire_ops_state_e;

    localparam logic [31:0] WIRE_OPS_LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] WIRE_OPS_DEFAULT_SEED = 32'h0000_0001;

    // Operands are passed zero-extended to 16 bits; callers truncate the result to their width.
    function automatic logic [15:0] wire_ops_golden(input logic [15:0] a,
                                                    input logic [15:0] b,
                                                    input logic        sel);
        return sel ? (a & b) : (a ^ b);
    endfunction

endpackage

// File: rtl/wire_ops_lfsr.sv
// 32-bit Galois right-shift LFSR with synchronous seed load and advance enable.
// Load has priority over advance.
module wire_ops_lfsr
    import wire_ops_pkg::*;
#(
    parameter logic [31:0] RST_VAL = WIRE_OPS_DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_seed,
    output logic [31:0] o_state
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    always_comb begin
        w_next = {1'b0, r_state[31:1]} ^ (r_state[0] ? WIRE_OPS_LFSR_TAPS : '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RST_VAL;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_advance) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/wire_ops_driver.sv
// Self-checking transmitter for WireOps: drives LFSR operands, delays the golden
// result by LATENCY cycles and compares it against the registered y.
module wire_ops_driver
    import wire_ops_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1,
    parameter logic [31:0] SEED    = WIRE_OPS_DEFAULT_SEED
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [15:0]      num_ops,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sel,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [15:0]      ops_checked,
    output logic [15:0]      err_count
);

    wire_ops_state_e r_state;
    wire_ops_state_e w_state_nxt;

    logic [15:0]      r_num_ops;
    logic [15:0]      r_issue_cnt;
    logic [3:0]       r_drain_cnt;
    logic [15:0]      r_ops_checked;
    logic [15:0]      r_err_count;
    logic [WIDTH-1:0] r_pipe_exp [LATENCY];
    logic [LATENCY-1:0] r_pipe_vld;

    logic             w_accept;
    logic             w_load;
    logic             w_run;
    logic [31:0]      w_lfsr;
    logic [WIDTH-1:0] w_exp;
    logic             w_chk_vld;

    wire_ops_lfsr #(
        .RST_VAL(SEED)
    ) u_lfsr (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_load   (w_load),
        .i_advance(w_run),
        .i_seed   (SEED),
        .o_state  (w_lfsr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (num_ops == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                // num_ops is nonzero here, so the subtraction cannot wrap.
                if (r_issue_cnt == r_num_ops - 16'd1) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_drain_cnt == 4'(LATENCY - 1)) w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_load    = w_accept && (num_ops != 16'd0);
    assign w_run     = (r_state == RUN);
    assign a         = w_run ? w_lfsr[WIDTH-1:0]     : '0;
    assign b         = w_run ? w_lfsr[WIDTH+15:16]   : '0;
    assign sel       = w_run ? w_lfsr[31]            : 1'b0;
    assign w_exp     = WIDTH'(wire_ops_golden(16'(a), 16'(b), sel));
    assign w_chk_vld = r_pipe_vld[LATENCY-1];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_num_ops     <= '0;
            r_issue_cnt   <= '0;
            r_drain_cnt   <= '0;
            r_ops_checked <= '0;
            r_err_count   <= '0;
            r_pipe_vld    <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) r_pipe_exp[i] <= '0;
        end else begin
            r_state <= w_state_nxt;

            r_pipe_vld[0] <= w_run;
            r_pipe_exp[0] <= w_exp;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_exp[i] <= r_pipe_exp[i-1];
            end

            if (w_run) r_issue_cnt <= r_issue_cnt + 16'd1;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 4'd1 : 4'd0;

            if (w_accept) begin
                r_num_ops     <= num_ops;
                r_issue_cnt   <= '0;
                r_ops_checked <= '0;
                r_err_count   <= '0;
            end else if (w_chk_vld) begin
                r_ops_checked <= r_ops_checked + 16'd1;
                if ((y != r_pipe_exp[LATENCY-1]) && (r_err_count != 16'hFFFF))
                    r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign ops_checked = r_ops_checked;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_wire_ops_driver.sv
// Directed bench for wire_ops_driver with a behavioural 1-cycle WireOps attached
// and an independent LFSR reference for the expected operand stream.
module tb_wire_ops_driver;

    localparam logic [31:0] TB_SEED = 32'h0000_0001;
    localparam logic [31:0] TB_TAPS = 32'h8020_0003;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic [15:0] num_ops = '0;
    logic [7:0]  a, b, y;
    logic        sel, busy, done;
    logic [15:0] ops_checked, err_count;

    logic [7:0]  r_y = '0;
    logic        y_flip = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    // Behavioural WireOps: registered result, with an optional bit-0 fault.
    always @(posedge sys_clk) r_y <= sel ? (a & b) : (a ^ b);
    assign y = r_y ^ {7'b0, y_flip};

    wire_ops_driver #(
        .WIDTH  (8),
        .LATENCY(1),
        .SEED   (TB_SEED)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .num_ops    (num_ops),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .ops_checked(ops_checked),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ TB_TAPS;
        return n;
    endfunction

    // Caller is on an IDLE cycle, 1 time unit after the edge; this is cycle 0.
    task automatic run_ops(input int n, input int f0, input int f1, input int f2,
                           input int exp_err);
        int          busy_cycles = 0;
        int          done_cyc    = -1;
        logic [31:0] m           = TB_SEED;
        start   = 1'b1;
        num_ops = 16'(n);
        for (int c = 1; c <= n + 20 && done_cyc < 0; c++) begin
            tick();
            start  = 1'b0;
            y_flip = (c == f0) || (c == f1) || (c == f2);
            if (busy) busy_cycles++;
            if (done) done_cyc = c;
            if (c <= n) begin
                check("abs", 32'({sel, b, a}), 32'({m[31], m[23:16], m[7:0]}));
                m = ref_next(m);
            end
        end
        y_flip = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(n + 2));
        check("busy_cycles", 32'(busy_cycles), 32'(n + 1));
        check("ops_checked", 32'(ops_checked), 32'(n));
        check("err_count", 32'(err_count), 32'(exp_err));
        tick();
    endtask

    initial begin
        int done_seen;

        #2;
        check("rst_outs", 32'({a, b, sel, busy, done}), 32'd0);
        check("rst_cnts", {ops_checked, err_count}, 32'd0);
        tick();
        tick();
        sys_rst = 1'b0;
        tick();

        // num_ops = 0: done the cycle after start, never busy.
        start   = 1'b1;
        num_ops = 16'd0;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done_off", 32'(done), 32'd0);
        check("zero_cnts", {ops_checked, err_count}, 32'd0);

        // Single op: a=01 b=00 sel=0, y=01, done in cycle 3.
        start   = 1'b1;
        num_ops = 16'd1;
        tick();
        start = 1'b0;
        check("one_a", 32'(a), 32'h01);
        check("one_b", 32'(b), 32'h00);
        check("one_sel", 32'(sel), 32'd0);
        check("one_busy", 32'(busy), 32'd1);
        tick();
        check("one_y", 32'(y), 32'h01);
        check("one_c2_busy", 32'(busy), 32'd1);
        check("one_c2_done", 32'(done), 32'd0);
        tick();
        check("one_done", 32'(done), 32'd1);
        check("one_ops", 32'(ops_checked), 32'd1);
        check("one_err", 32'(err_count), 32'd0);
        tick();

        // Two clean 100-op runs must replay the same stream, then a faulted run.
        run_ops(100, -1, -1, -1, 0);
        run_ops(100, -1, -1, -1, 0);
        run_ops(100, 10, 50, 77, 3);

        // Reset asserted mid-run.
        start   = 1'b1;
        num_ops = 16'd100;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
        end
        sys_rst = 1'b1;
        #1;
        check("mid_rst_outs", 32'({a, b, sel, busy, done}), 32'd0);
        check("mid_rst_cnts", {ops_checked, err_count}, 32'd0);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) done_seen++;
        end
        sys_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("mid_rst_quiet", 32'(done_seen), 32'd0);
        run_ops(5, -1, -1, -1, 0);

        // start held high: accepted only on the IDLE cycle (13), new run from cycle 14.
        start     = 1'b1;
        num_ops   = 16'd10;
        done_seen = 0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (done) done_seen++;
            if (c == 12) check("hold_done12", 32'(done), 32'd1);
            if (c == 13) check("hold_idle13", 32'(busy), 32'd0);
        end
        check("hold_one_done", 32'(done_seen), 32'd1);
        tick();
        start = 1'b0;
        check("hold_rerun_busy", 32'(busy), 32'd1);
        check("hold_rerun_a", 32'({sel, b, a}), 32'h0000_0001);
        done_seen = 0;
        for (int c = 15; c <= 40 && done_seen == 0; c++) begin
            tick();
            if (done) done_seen = c;
        end
        check("hold_rerun_done", 32'(done_seen), 32'd25);
        check("hold_rerun_ops", 32'(ops_checked), 32'd10);
        check("hold_rerun_err", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
